// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command bytes and parity helper
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, TX, ACK, WAIT_IDLE} ps2_state_e;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_command_sender_if.sv
// ps2_command_sender_if: application-side command request and status handshake
interface ps2_command_sender_if;
    logic [7:0] command_to_send;
    logic       send_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       error_no_ack;
    modport master (output command_to_send, send_command,
                    input busy, command_was_sent, error_communication_timed_out, error_no_ack);
    modport slave  (input command_to_send, send_command,
                    output busy, command_was_sent, error_communication_timed_out, error_no_ack);
endinterface

// File: rtl/ps2_input_sync.sv
// ps2_input_sync: 2-FF synchronizer for PS2_CLK/PS2_DAT plus clock falling-edge detect
module ps2_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic clk_fall_o
);
    logic [1:0] clk_q, dat_q;
    logic       prev_q;
    // Reset to the idle-high bus level so no false edge appears after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_q  <= 2'b11;
            dat_q  <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            clk_q  <= {clk_q[0], ps2_clk_i};
            dat_q  <= {dat_q[0], ps2_dat_i};
            prev_q <= clk_q[1];
        end
    end
    assign clk_o      = clk_q[1];
    assign dat_o      = dat_q[1];
    assign clk_fall_o = prev_q & ~clk_q[1];
endmodule

// File: rtl/ps2_command_sender.sv
// ps2_command_sender: PS/2 host-to-device command transmitter with ACK check and timeouts
module ps2_command_sender
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int REQUEST_CYCLES       = 50,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int FRAME_TIMEOUT_CYCLES = 100000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ps2_command_sender_if.slave  cmd,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_dat_in,
    output logic                 ps2_clk_oe,
    output logic                 ps2_dat_oe
);
    ps2_state_e  state_q, state_d;
    logic [19:0] cnt_q, cnt_d, frm_q, frm_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  data_q, data_d;
    logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic        done_q, done_d, tmo_q, tmo_d, nak_q, nak_d;
    logic        clk_s, dat_s, clk_fall, expired;

    ps2_input_sync u_sync (
        .clk        (CLOCK_50),
        .rst        (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .clk_o      (clk_s),
        .dat_o      (dat_s),
        .clk_fall_o (clk_fall)
    );

    // Start timer guards TX until the first edge; frame timer covers the rest
    assign expired = (state_q == TX && bit_q == 4'd0) ? cnt_q == 20'(START_TIMEOUT_CYCLES - 1)
                   : (state_q == TX || state_q == ACK || state_q == WAIT_IDLE) && frm_q == 20'(FRAME_TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 20'd1;
        frm_d    = 20'd0;
        bit_d    = bit_q;
        data_d   = data_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        nak_d    = 1'b0;
        case (state_q)
            IDLE: begin
                bit_d    = 4'd0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd.send_command && !(done_q | tmo_q | nak_q)) begin
                    state_d  = INHIBIT;
                    data_d   = {odd_parity(cmd.command_to_send), cmd.command_to_send};
                    clk_oe_d = 1'b1;
                end
            end
            INHIBIT: if (cnt_q == 20'(INHIBIT_CYCLES - 1)) begin
                state_d  = REQUEST;
                dat_oe_d = 1'b1;
            end
            REQUEST: if (cnt_q == 20'(REQUEST_CYCLES - 1)) begin
                state_d  = TX;
                clk_oe_d = 1'b0;
            end
            TX: begin
                frm_d = bit_q == 4'd0 ? 20'd0 : frm_q + 20'd1;
                if (clk_fall) begin
                    bit_d    = bit_q + 4'd1;
                    dat_oe_d = bit_q < 4'd9 ? ~data_q[bit_q] : 1'b0;
                    state_d  = bit_q == 4'd9 ? ACK : TX;
                end
            end
            ACK: begin
                frm_d = frm_q + 20'd1;
                if (clk_fall) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = dat_s ? IDLE : WAIT_IDLE;
                    nak_d   = dat_s;
                end
            end
            WAIT_IDLE: begin
                frm_d = frm_q + 20'd1;
                if (clk_s && dat_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (expired) begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            tmo_d    = 1'b1;
            nak_d    = 1'b0;
            done_d   = 1'b0;
        end
        if (state_d != state_q) cnt_d = 20'd0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 20'd0;
            frm_q    <= 20'd0;
            bit_q    <= 4'd0;
            data_q   <= 9'd0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            nak_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frm_q    <= frm_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            nak_q    <= nak_d;
        end
    end

    assign ps2_clk_oe                        = clk_oe_q;
    assign ps2_dat_oe                        = dat_oe_q;
    assign cmd.busy                          = state_q != IDLE;
    assign cmd.command_was_sent              = done_q;
    assign cmd.error_communication_timed_out = tmo_q;
    assign cmd.error_no_ack                  = nak_q;
endmodule
